// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcode encodings, instruction fields and fetch states.
// FETCH_HALT_EN adds the HALT fetch state.
package cpu_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ALU   = 2'b11;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;

  localparam logic [7:0] HALT_INSTR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
`ifdef FETCH_HALT_EN
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
`else
    ST_ISSUE = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack fetch and valid/ready issue to the control unit.
// Define FETCH_HALT_EN to stop fetching after the HALT instruction is consumed.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [1:0]         opcode,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          id_instr_d = imem_rdata;
          id_pc_d    = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (id_ready) begin
          state_d = ST_FETCH;
`ifdef FETCH_HALT_EN
          if (id_instr_q == INSTR_W'(HALT_INSTR)) state_d = ST_HALT;
`endif
        end
      end
      default: state_d = state_q;
    endcase

    // A redirect overrides everything, dropping any ack that arrived alongside it.
    if (redirect_valid && (state_q == ST_FETCH || state_q == ST_ISSUE)) begin
      pc_d       = redirect_pc;
      state_d    = ST_FETCH;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign id_valid  = (state_q == ST_ISSUE);
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign opcode    = id_valid ? id_instr_q[INSTR_W-1:INSTR_W-2] : OP_NOP;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
